// File: rtl/io_active_multi.sv
// io_active_multi: multi-channel I/O port window decoder. Each channel address
// is range-checked against the port window and turned into a one-hot port
// vector, which then travels down a PIPE_DEPTH-stage pipeline with
// hold/annul control. The output stage drives the stall flag and the
// per-port saturating access counters.
module io_active_multi #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned PORT_COUNT     = 4,
  parameter int unsigned PORT_BASE_ADDR = 1020,
  parameter int unsigned CHANNEL_COUNT  = 2,
  parameter int unsigned PIPE_DEPTH     = 1,
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned SEL_WIDTH      = 2
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [CHANNEL_COUNT-1:0]            enable,
  input  logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] addr,
  input  logic [PORT_COUNT-1:0]               port_ready,
  input  logic                                hold,
  input  logic                                annul,
  input  logic [SEL_WIDTH-1:0]                count_sel,
  input  logic                                count_clear,
  output logic [CHANNEL_COUNT*PORT_COUNT-1:0] active,
  output logic [CHANNEL_COUNT-1:0]            hit,
  output logic                                collision,
  output logic                                stall,
  output logic [COUNT_WIDTH-1:0]              access_count
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  localparam int unsigned AW  = CHANNEL_COUNT * PORT_COUNT;
  // One extra bit so the window end never wraps and no address aliases.
  localparam logic [ADDR_WIDTH:0] BASE = AW1'(PORT_BASE_ADDR);

  if (PIPE_DEPTH < 1) begin : g_bad_depth
    $error("io_active_multi: PIPE_DEPTH must be >= 1");
  end
  if (PORT_COUNT < 1) begin : g_bad_ports
    $error("io_active_multi: PORT_COUNT must be >= 1");
  end
  if (CHANNEL_COUNT < 1) begin : g_bad_channels
    $error("io_active_multi: CHANNEL_COUNT must be >= 1");
  end
  if (SEL_WIDTH < $clog2(PORT_COUNT)) begin : g_bad_sel
    $error("io_active_multi: SEL_WIDTH too narrow for PORT_COUNT");
  end
  if ((longint'(PORT_BASE_ADDR) + longint'(PORT_COUNT)) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_window
    $error("io_active_multi: port window exceeds address space");
  end

  logic [AW-1:0]            dec_active;
  logic                     dec_coll;
  logic [PORT_COUNT-1:0]    port_seen;
  logic [AW-1:0]            pipe_active [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0]    pipe_coll;
  logic [PORT_COUNT-1:0]    port_any;
  logic [COUNT_WIDTH-1:0]   cnt [PORT_COUNT];
  logic                     advance;

  // Decode every channel address to a one-hot port vector and flag port collisions.
  always_comb begin
    dec_active = '0;
    dec_coll   = 1'b0;
    port_seen  = '0;
    for (int unsigned c = 0; c < CHANNEL_COUNT; c++) begin
      for (int unsigned p = 0; p < PORT_COUNT; p++) begin
        if (enable[c] && ({1'b0, addr[c*ADDR_WIDTH +: ADDR_WIDTH]} == (BASE + AW1'(p)))) begin
          dec_active[c*PORT_COUNT + p] = 1'b1;
          if (port_seen[p]) dec_coll = 1'b1;
          port_seen[p] = 1'b1;
        end
      end
    end
  end

  // First pipeline stage: annul clears, hold freezes, otherwise sample the decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_active[0] <= '0;
      pipe_coll[0]   <= 1'b0;
    end else if (annul) begin
      pipe_active[0] <= '0;
      pipe_coll[0]   <= 1'b0;
    end else if (!hold) begin
      pipe_active[0] <= dec_active;
      pipe_coll[0]   <= dec_coll;
    end
  end

  for (genvar g = 1; g < PIPE_DEPTH; g++) begin : g_stage
    // Later pipeline stages: same annul/hold priority, shift from the previous stage.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pipe_active[g] <= '0;
        pipe_coll[g]   <= 1'b0;
      end else if (annul) begin
        pipe_active[g] <= '0;
        pipe_coll[g]   <= 1'b0;
      end else if (!hold) begin
        pipe_active[g] <= pipe_active[g-1];
        pipe_coll[g]   <= pipe_coll[g-1];
      end
    end
  end

  assign active    = pipe_active[PIPE_DEPTH-1];
  assign collision = pipe_coll[PIPE_DEPTH-1];

  // Per-channel hit, per-port activity and stall from the output stage.
  always_comb begin
    hit      = '0;
    port_any = '0;
    for (int unsigned c = 0; c < CHANNEL_COUNT; c++) begin
      hit[c]   = |active[c*PORT_COUNT +: PORT_COUNT];
      port_any = port_any | active[c*PORT_COUNT +: PORT_COUNT];
    end
    stall   = |(port_any & ~port_ready);
    advance = !hold && !annul && !stall;
  end

  // Saturating per-port counters; at most one increment per port per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < PORT_COUNT; p++) cnt[p] <= '0;
    end else if (count_clear) begin
      for (int unsigned p = 0; p < PORT_COUNT; p++) cnt[p] <= '0;
    end else if (advance) begin
      for (int unsigned p = 0; p < PORT_COUNT; p++) begin
        if (port_any[p] && port_ready[p] && (cnt[p] != '1)) cnt[p] <= cnt[p] + 1'b1;
      end
    end
  end

  // Counter readback; selects beyond the port range read as zero.
  always_comb begin
    access_count = '0;
    for (int unsigned p = 0; p < PORT_COUNT; p++) begin
      if (count_sel == SEL_WIDTH'(p)) access_count = cnt[p];
    end
  end

endmodule

// File: tb/tb_io_active_multi.sv
// Directed bench for io_active_multi: one default instance (A) and one with a
// 3-deep pipeline and 2-bit counters (B).
module tb_io_active_multi;

  logic       clock = 1'b0;
  logic       reset_n;
  int         tests = 0;
  int         fails = 0;

  logic [1:0]  en_a, hit_a, sel_a;
  logic [19:0] addr_a;
  logic [3:0]  rdy_a;
  logic        hold_a, annul_a, clr_a, coll_a, stall_a;
  logic [7:0]  act_a, cnt_a;

  logic [1:0]  en_b, hit_b, sel_b, cnt_b;
  logic [19:0] addr_b;
  logic [3:0]  rdy_b;
  logic        hold_b, annul_b, clr_b, coll_b, stall_b;
  logic [7:0]  act_b;

  always #5 clock = ~clock;

  io_active_multi dut_a (
    .clock(clock), .reset_n(reset_n), .enable(en_a), .addr(addr_a),
    .port_ready(rdy_a), .hold(hold_a), .annul(annul_a), .count_sel(sel_a),
    .count_clear(clr_a), .active(act_a), .hit(hit_a), .collision(coll_a),
    .stall(stall_a), .access_count(cnt_a)
  );

  io_active_multi #(.PIPE_DEPTH(3), .COUNT_WIDTH(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(en_b), .addr(addr_b),
    .port_ready(rdy_b), .hold(hold_b), .annul(annul_b), .count_sel(sel_b),
    .count_clear(clr_b), .active(act_b), .hit(hit_b), .collision(coll_b),
    .stall(stall_b), .access_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    en_a = '0; addr_a = '0; rdy_a = 4'hf; hold_a = 0; annul_a = 0; sel_a = '0; clr_a = 0;
    en_b = '0; addr_b = '0; rdy_b = 4'hf; hold_b = 0; annul_b = 0; sel_b = '0; clr_b = 0;
    #1;
    chk("rst_act_a", act_a, 0);   chk("rst_hit_a", hit_a, 0);
    chk("rst_coll_a", coll_a, 0); chk("rst_stall_a", stall_a, 0);
    chk("rst_cnt_a", cnt_a, 0);   chk("rst_act_b", act_b, 0);
    #11 reset_n = 1'b1;

    // basic decode: ch0=1021 -> port1, ch1=1019 below window
    en_a = 2'b11; addr_a = {10'd1019, 10'd1021}; sel_a = 2'd1;
    tick();
    chk("dec_act", act_a, 8'h02); chk("dec_hit", hit_a, 2'b01);
    chk("dec_coll", coll_a, 0);   chk("dec_stall", stall_a, 0);
    chk("dec_cnt1_pre", cnt_a, 0);

    // both channels on port3: collision, no priority masking
    addr_a = {10'd1023, 10'd1023};
    tick();
    chk("col_act", act_a, 8'h88); chk("col_hit", hit_a, 2'b11);
    chk("col_coll", coll_a, 1);   chk("cnt1_after", cnt_a, 1);
    en_a = 2'b00; sel_a = 2'd3;
    tick();
    chk("col_cnt3_once", cnt_a, 1); chk("idle_act", act_a, 0); chk("idle_coll", coll_a, 0);

    // stall: port2 not ready
    en_a = 2'b01; addr_a = {10'd0, 10'd1022}; rdy_a = 4'b1011; sel_a = 2'd2;
    tick();
    chk("stall_act", act_a, 8'h04); chk("stall_on", stall_a, 1);
    tick();
    chk("stall_cnt2_held", cnt_a, 0); chk("stall_still", stall_a, 1);
    rdy_a = 4'hf; #1;
    chk("stall_off", stall_a, 0);
    en_a = 2'b00;
    tick();
    chk("cnt2_inc", cnt_a, 1);

    // disabled channel, window start, aliasing addresses
    en_a = 2'b10; addr_a = {10'd1020, 10'd1021};
    tick();
    chk("dis_act", act_a, 8'h10); chk("dis_hit", hit_a, 2'b10);
    en_a = 2'b11; addr_a = {10'd1019, 10'd1};
    tick();
    chk("alias_act", act_a, 0); chk("alias_hit", hit_a, 0);

    // count_clear
    en_a = 2'b00; clr_a = 1; sel_a = 2'd2;
    tick();
    chk("clr_cnt2", cnt_a, 0);
    clr_a = 0;

    // hold freezes, annul beats hold
    en_a = 2'b01; addr_a = {10'd0, 10'd1021};
    tick();
    chk("hold_load", act_a, 8'h02);
    hold_a = 1; addr_a = {10'd0, 10'd1022};
    tick();
    chk("hold_keep", act_a, 8'h02);
    annul_a = 1;
    tick();
    chk("annul_act", act_a, 0); chk("annul_hit", hit_a, 0);
    hold_a = 0; annul_a = 0;

    // asynchronous reset mid-stream
    en_a = 2'b11; addr_a = {10'd1023, 10'd1023}; rdy_a = 4'b0111; sel_a = 2'd3;
    tick();
    chk("pre_rst_act", act_a, 8'h88); chk("pre_rst_stall", stall_a, 1);
    chk("pre_rst_coll", coll_a, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_act", act_a, 0);    chk("mid_rst_hit", hit_a, 0);
    chk("mid_rst_coll", coll_a, 0);  chk("mid_rst_stall", stall_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    en_a = 2'b00; rdy_a = 4'hf;
    #2 reset_n = 1'b1;

    // depth-3 pipeline with two hold cycles
    en_b = 2'b01; addr_b = {10'd0, 10'd1020}; sel_b = 2'd0;
    tick();
    chk("p3_e0", act_b, 0);
    en_b = 2'b00; hold_b = 1;
    tick(); chk("p3_e1", act_b, 0);
    tick(); chk("p3_e2", act_b, 0);
    hold_b = 0;
    tick(); chk("p3_e3", act_b, 0);
    tick(); chk("p3_e4_act", act_b, 8'h01); chk("p3_e4_hit", hit_b, 2'b01);
    tick(); chk("p3_e5_act", act_b, 0);     chk("p3_cnt0", cnt_b, 1);

    // annul wipes the in-flight entry
    en_b = 2'b01;
    tick();
    en_b = 2'b00; hold_b = 1;
    tick();
    hold_b = 0; annul_b = 1;
    tick();
    annul_b = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("p3_annul_flush", act_b, 0);
    end

    // 2-bit counter saturation
    clr_b = 1;
    tick();
    clr_b = 0;
    chk("sat_clr", cnt_b, 0);
    en_b = 2'b01;
    repeat (3) tick();
    chk("sat_act", act_b, 8'h01); chk("sat_c0", cnt_b, 0);
    tick(); chk("sat_c1", cnt_b, 1);
    tick(); chk("sat_c2", cnt_b, 2);
    tick(); chk("sat_c3", cnt_b, 3);
    tick(); chk("sat_hold3", cnt_b, 3);
    clr_b = 1;
    tick(); chk("clr_beats_inc", cnt_b, 0);
    clr_b = 0;
    tick(); chk("inc_after_clr", cnt_b, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_active_multi.md
Name: io_active_multi

Overview:
- Multi-channel, pipelined successor to the single-address I/O port "active" generator.
- Decodes CHANNEL_COUNT operand addresses against the I/O port window using a true range check, not a truncated translation.
- Emits per-channel one-hot port-active vectors through a configurable-depth pipeline, with hold/annul control, port-not-ready stall, cross-channel collision flag and per-port saturating access counters.
- Sits between the instruction address stage and the I/O port interfaces of the datapath.

Parameters:
- ADDR_WIDTH, 10, width of each channel address.
- PORT_COUNT, 4, number of I/O ports in the window.
- PORT_BASE_ADDR, 1020, first address of the port window.
- CHANNEL_COUNT, 2, number of independent address channels (e.g. read A, read B).
- PIPE_DEPTH, 1, register stages from address to active output; must be >=1.
- COUNT_WIDTH, 8, width of each per-port access counter.
- SEL_WIDTH, 2, width of the counter select; must be >= clog2(PORT_COUNT).

Ports:
- clock  in  1  system clock, all state rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  CHANNEL_COUNT  per-channel address valid.
- addr  in  CHANNEL_COUNT*ADDR_WIDTH  channel c at bits [c*ADDR_WIDTH +: ADDR_WIDTH].
- port_ready  in  PORT_COUNT  1 = port can complete an access (not empty/full).
- hold  in  1  freeze pipeline contents.
- annul  in  1  clear all pipeline stages.
- count_sel  in  SEL_WIDTH  port whose counter is shown.
- count_clear  in  1  synchronous clear of all counters.
- active  out  CHANNEL_COUNT*PORT_COUNT  channel c one-hot at [c*PORT_COUNT +: PORT_COUNT].
- hit  out  CHANNEL_COUNT  channel c addressed a port; equals OR of its active slice.
- collision  out  1  two or more channels hit the same port in the same input cycle.
- stall  out  1  an active port is not ready.
- access_count  out  COUNT_WIDTH  counter of the port selected by count_sel.

Behaviour:
- Reset (reset_n=0, async): all pipeline stages and counters cleared. active=0, hit=0, collision=0, stall=0, access_count=0.
- Decode (combinational, stage input):
  - hit_c = enable[c] && addr_c >= PORT_BASE_ADDR && addr_c < PORT_BASE_ADDR+PORT_COUNT.
  - Compare uses the full ADDR_WIDTH; no aliasing.
  - Port index = addr_c - PORT_BASE_ADDR; one-hot bit set only if hit_c.
- Collision: decoded for the same input cycle as the addresses and carried down the pipeline with them. All channels' active bits are still asserted on a collision; there is no priority masking.
- Pipeline:
  - PIPE_DEPTH stages; active, hit and collision appear exactly PIPE_DEPTH cycles after addr/enable are sampled.
  - Each edge: if annul=1, all stages are cleared to 0. Annul has priority over hold.
  - Else if hold=1, all stages retain their values and the input is not sampled.
  - Else the pipeline shifts one stage.
- Stall: combinational from the output stage and port_ready. stall = OR over p of (any channel active on p) && !port_ready[p]. The block does not self-freeze on stall; upstream drives hold.
- Counters, one per port, COUNT_WIDTH bits, saturating at all-ones:
  - Increment at an edge when hold=0 && annul=0 && stall=0, the output stage has port p active on any channel, and port_ready[p]=1.
  - Maximum +1 per cycle even if several channels hit p.
  - count_clear=1 zeroes all counters at the edge; clear beats increment.
- access_count = counter[count_sel], combinational; 0 if count_sel >= PORT_COUNT.
- Reset mid-operation: immediately empties the pipeline and counters. The first valid output after release comes PIPE_DEPTH cycles after the first sampled input.
- Elaboration error if PIPE_DEPTH<1, PORT_COUNT<1, CHANNEL_COUNT<1, SEL_WIDTH<clog2(PORT_COUNT), or PORT_BASE_ADDR+PORT_COUNT > 2**ADDR_WIDTH.

Test Plan:
- Defaults; ch0 addr=1021 en=1, ch1 addr=1019 en=1, all ready -> next cycle active[3:0]=0010, active[7:4]=0000, hit=01, collision=0, stall=0.
- ch0=1023, ch1=1023 both enabled -> active=1000_1000, hit=11, collision=1. Counter[3] +1 (not +2): count_sel=3 gives 1.
- PIPE_DEPTH=3, ch0=1020 at cycle 0, hold=1 during cycles 1-2 -> active[0] first asserted at cycle 5. With annul at cycle 2 instead -> never asserted.
- ch0=1022, port_ready=1011 -> stall=1, counter[2] unchanged. Raise port_ready[2] -> stall=0, counter[2] increments.
- COUNT_WIDTH=2: four consecutive ready hits on port 0 -> access_count saturates at 3. count_clear together with a hit -> access_count=0.
- Assert reset_n=0 mid-stream with nonzero pipeline -> active, hit, collision and stall all 0 with no clock edge; ch0 enable=0 with addr=1021 -> active=0.
